tri_packer: RTL and testbench
=============================

# tri_packer

Triangle word transmitter feeding the lambda generator. It accepts a serial stream of screen-space vertices and groups every three accepted vertices into one triangle. It stamps each triangle with a wrapping ID and can cull zero-area triangles. Packed 128-bit words go into a small FIFO and are driven onto the lambda generator's `valid`/`input_bus`/`stall` interface.

## Interface
- `XWIDTH`, 9: vertex x width, unsigned.
- `YWIDTH`, 8: vertex y width, unsigned.
- `ZWIDTH`, 16: vertex depth width, signed.
- `IDWIDTH`, 16: triangle ID width. The packed layout is fixed to the default widths.
- `FIFO_DEPTH`, 4: triangle words buffered; must be a power of 2 and at least 2.
- `CULL_DEGEN`, 1: 1 drops zero-area triangles; 0 passes every triangle.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `frame_start`  in  1  synchronous pulse that clears the ID counter and any partial triangle.
- `vtx_valid`  in  1  vertex offered.
- `vtx_ready`  out  1  vertex accepted when `vtx_valid && vtx_ready`.
- `vtx_x`  in  XWIDTH  vertex x.
- `vtx_y`  in  YWIDTH  vertex y.
- `vtx_z`  in  ZWIDTH  vertex z.
- `valid`  out  1  `bus` holds a triangle word.
- `bus`  out  128  packed triangle word.
- `stall`  in  1  downstream hold; the word is consumed on any cycle with `valid && !stall`.
- `cull_count`  out  16  culled-triangle count, saturating at 0xFFFF.

## Operation
- Assembler FSM states: `V0`, `V1`, `V2`. Each state is the index of the next vertex to capture.
  - An accepted vertex in `V0` latches v1 and moves to `V1`.
  - An accepted vertex in `V1` latches v2 and moves to `V2`.
  - An accepted vertex in `V2` completes the triangle and returns to `V0`.
- `vtx_ready = (state != V2) || !fifo_full`. `vtx_ready` must have no combinational path from `stall`.
- Area test on completion, with x and y zero-extended and computed at signed width 20:
  - A = (x2−x1)(y3−y1) − (x3−x1)(y2−y1).
  - If `CULL_DEGEN` and A == 0: no FIFO push, `tid` unchanged, `cull_count` increments and saturates.
  - Otherwise push the word and then `tid <= tid + 1`, wrapping 0xFFFF→0.
- Packing, MSB first:
  - [127:112] tid, [111:96] z1, [95:88] 0.
  - [87:80] y1, [79:72] y2, [71:64] y3, [63:59] 0.
  - [58:50] x1, [49:41] x2, [40:32] x3.
  - [31:16] z2, [15:0] z3.
- FIFO is first-word-fall-through.
  - `valid = !empty`.
  - `bus` = head word when valid, otherwise 128'h0.
  - Pop on `valid && !stall`.
  - Push and pop in the same cycle are allowed at any occupancy below full.
- `frame_start`:
  - Forces the FSM to `V0` and discards latched vertices.
  - Sets `tid <= 0`.
  - Leaves the FIFO contents and `cull_count` untouched.
  - A vertex accepted in the same cycle is discarded. `vtx_ready` is unaffected.
- A push is never lost: a push cannot happen when the FIFO is full, because `vtx_ready` is low in `V2` when full.

## Timing
- Reset (async assert) values:
  - FSM `V0`, `tid` 0, FIFO empty, `cull_count` 0.
  - `valid` 0, `bus` 0, `vtx_ready` 1.
- Reset release is synchronized internally. The first vertex can be accepted on the second rising edge after deassertion.
- Latency: third vertex accepted at edge N. With an empty FIFO, `valid` is high and `bus` is valid in the cycle after edge N, i.e. 1 cycle.
- Throughput: one triangle per 3 vertex cycles. The FIFO drains at 1 word/cycle while `stall` is low.
- While `stall` is high, `valid` and `bus` hold stable. A word never changes or disappears without a pop.
- Full boundary:
  - FIFO full and FSM in `V2`: `vtx_ready` is 0.
  - A pop at edge N makes `vtx_ready` 1 in the cycle after N.
- Reset mid-triangle or mid-stall: the FIFO is flushed and `valid` drops asynchronously.

## Test plan
- **Single triangle.** After reset, send vertices (10,20,0x0100), (30,20,0x0200), (10,50,0xFFFF) with `stall`=0.
  - `valid` rises exactly 1 cycle after the third accept.
  - `bus` = 0000_0100_00_14_14_32_0_00A_01E_00A_0200_FFFF packed per the layout, for 1 cycle.
- **Degenerate cull.** Send three collinear vertices (0,0), (5,5), (10,10), then one valid triangle.
  - No word is pushed for the collinear triangle and `cull_count` becomes 1.
  - The valid triangle carries tid 0.
  - Repeat with `CULL_DEGEN`=0: the collinear triangle is emitted with tid 0.
- **Backpressure.** Hold `stall`=1 and stream 15 vertices.
  - `vtx_ready` drops when the 4th word is pending and the FSM is in `V2`. `bus` stays fixed at tid 0.
  - Release `stall`: words tid 0..4 emerge in order, one per cycle, with no gaps, drops or duplicates.
- **ID wrap and frame_start.**
  - Preload 65535 triangles (or force `tid`=0xFFFE): consecutive words carry tid 0xFFFE, 0xFFFF, 0x0000.
  - Pulse `frame_start` after two vertices: the partial triangle is discarded and the next word carries tid 0.
- **Async reset mid-stall.** With 3 words queued and `stall`=1, assert `rst` between clock edges.
  - `valid` and `bus` go to 0 immediately and `vtx_ready` goes to 1.
  - The next triangle carries tid 0.

Source files
------------

// File: rtl/tri_packer.sv
// rtl/tri_packer.sv - groups serial vertices into triangles, culls zero-area ones, queues packed words
module tri_packer #(
  parameter int XWIDTH     = 9,
  parameter int YWIDTH     = 8,
  parameter int ZWIDTH     = 16,
  parameter int IDWIDTH    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CULL_DEGEN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              vtx_valid,
  output logic              vtx_ready,
  input  logic [XWIDTH-1:0] vtx_x,
  input  logic [YWIDTH-1:0] vtx_y,
  input  logic [ZWIDTH-1:0] vtx_z,
  output logic              valid,
  output logic [127:0]      bus,
  input  logic              stall,
  output logic [15:0]       cull_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {V0, V1, V2} state_t;

  state_t              r_state;
  logic                r_run;
  logic [XWIDTH-1:0]   r_x1, r_x2;
  logic [YWIDTH-1:0]   r_y1, r_y2;
  logic [ZWIDTH-1:0]   r_z1, r_z2;
  logic [IDWIDTH-1:0]  r_tid;
  logic [15:0]         r_cull;
  logic [127:0]        r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wr, r_rd;

  logic                w_empty, w_full, w_acc, w_done, w_cull, w_push, w_pop;
  logic signed [19:0]  w_x1, w_x2, w_x3, w_y1, w_y2, w_y3;
  logic signed [19:0]  w_dx21, w_dy31, w_dx31, w_dy21, w_area;
  logic [127:0]        w_word;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

  // Only the V2 accept can push, so readiness depends on state and occupancy alone.
  assign vtx_ready = (r_state != V2) || !w_full;

  // r_run gates acceptance until the cycle after reset release.
  assign w_acc  = r_run && vtx_valid && vtx_ready && !frame_start;
  assign w_done = w_acc && (r_state == V2);

  assign w_x1 = 20'(r_x1);
  assign w_x2 = 20'(r_x2);
  assign w_x3 = 20'(vtx_x);
  assign w_y1 = 20'(r_y1);
  assign w_y2 = 20'(r_y2);
  assign w_y3 = 20'(vtx_y);

  assign w_dx21 = w_x2 - w_x1;
  assign w_dy31 = w_y3 - w_y1;
  assign w_dx31 = w_x3 - w_x1;
  assign w_dy21 = w_y2 - w_y1;
  assign w_area = (w_dx21 * w_dy31) - (w_dx31 * w_dy21);

  assign w_cull = (CULL_DEGEN != 0) && (w_area == 20'sd0);
  assign w_push = w_done && !w_cull;
  assign w_pop  = !w_empty && !stall;

  assign w_word = {r_tid, r_z1, 8'h00, r_y1, r_y2, vtx_y,
                   5'h00, r_x1, r_x2, vtx_x, r_z2, vtx_z};

  assign valid      = !w_empty;
  assign bus        = w_empty ? 128'h0 : r_mem[r_rd[AW-1:0]];
  assign cull_count = r_cull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_state <= V0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_y1    <= '0;
      r_y2    <= '0;
      r_z1    <= '0;
      r_z2    <= '0;
      r_tid   <= '0;
      r_cull  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      r_run <= 1'b1;
      if (frame_start) begin
        r_state <= V0;
        r_tid   <= '0;
      end else if (w_acc) begin
        case (r_state)
          V0: begin
            r_x1    <= vtx_x;
            r_y1    <= vtx_y;
            r_z1    <= vtx_z;
            r_state <= V1;
          end
          V1: begin
            r_x2    <= vtx_x;
            r_y2    <= vtx_y;
            r_z2    <= vtx_z;
            r_state <= V2;
          end
          default: begin
            r_state <= V0;
            if (w_push) r_tid <= r_tid + 1'b1;
          end
        endcase
      end
      if (w_done && w_cull && (r_cull != 16'hFFFF)) r_cull <= r_cull + 16'd1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_word;
  end

endmodule

// File: tb/tb_tri_packer.sv
// tb/tb_tri_packer.sv - scoreboard bench for tri_packer with culling and non-culling instances
module tb_tri_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic         vtx_valid = 1'b0;
  logic [8:0]   vtx_x = '0;
  logic [7:0]   vtx_y = '0;
  logic [15:0]  vtx_z = '0;
  logic         stall = 1'b0;
  logic         stall_nc = 1'b0;
  logic         vtx_ready, valid;
  logic [127:0] bus;
  logic [15:0]  cull_count;
  logic         vtx_valid_nc, vtx_ready_nc, valid_nc;
  logic [127:0] bus_nc;
  logic [15:0]  cull_count_nc;

  always #5 clk = ~clk;

  assign vtx_valid_nc = vtx_valid && vtx_ready;

  tri_packer u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
    .valid(valid), .bus(bus), .stall(stall), .cull_count(cull_count)
  );

  tri_packer #(.CULL_DEGEN(0)) u_nc (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .vtx_valid(vtx_valid_nc), .vtx_ready(vtx_ready_nc),
    .vtx_x(vtx_x), .vtx_y(vtx_y), .vtx_z(vtx_z),
    .valid(valid_nc), .bus(bus_nc), .stall(stall_nc), .cull_count(cull_count_nc)
  );

  typedef struct {
    logic [26:0] xs;
    logic [23:0] ys;
    logic [47:0] zs;
    bit          cull;
  } tri_vec_t;

  tri_vec_t     tbl [6];
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];
  logic [8:0]   mx [3];
  logic [7:0]   my [3];
  logic [15:0]  mz [3];
  int           mcnt = 0;
  int           acc_total = 0;
  int           cull_exp = 0;
  logic [15:0]  tid1 = '0;
  logic [15:0]  tid2 = '0;
  bit           cur_cull = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [15:0] tid);
    return {tid, mz[0], 8'h00, my[0], my[1], my[2], 5'h00, mx[0], mx[1], mx[2], mz[1], mz[2]};
  endfunction

  task automatic model_clear();
    q1.delete();
    q2.delete();
    mcnt = 0;
    tid1 = '0;
    tid2 = '0;
    cull_exp = 0;
  endtask

  task automatic model_accept(input logic [8:0] x, input logic [7:0] y, input logic [15:0] z);
    mx[mcnt] = x;
    my[mcnt] = y;
    mz[mcnt] = z;
    mcnt++;
    acc_total++;
    if (mcnt == 3) begin
      mcnt = 0;
      q2.push_back(pack(tid2));
      tid2++;
      if (cur_cull) cull_exp++;
      else begin
        q1.push_back(pack(tid1));
        tid1++;
      end
    end
  endtask

  task automatic send_vtx(input logic [8:0] x, input logic [7:0] y, input logic [15:0] z);
    bit done = 1'b0;
    vtx_x = x;
    vtx_y = y;
    vtx_z = z;
    vtx_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (vtx_ready) begin
        @(posedge clk);
        model_accept(x, y, z);
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
    end
    #1;
    vtx_valid = 1'b0;
    if (!done) check("vertex accept timeout", 128'd0, 128'd1);
  endtask

  task automatic send_tri(input tri_vec_t v);
    cur_cull = v.cull;
    for (int k = 0; k < 3; k++)
      send_vtx(v.xs[9*(2-k) +: 9], v.ys[8*(2-k) +: 8], v.zs[16*(2-k) +: 16]);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    @(posedge clk);
    mcnt = 0;
    tid1 = '0;
    tid2 = '0;
    #1;
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (q1.size() != 0 || q2.size() != 0); t++) @(posedge clk);
    @(negedge clk);
    check("drain dut queue empty", 128'(q1.size()), 128'd0);
    check("drain nc queue empty", 128'(q2.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && !stall) begin
        if (q1.size() == 0) check("dut unexpected word", bus, 128'd0);
        else check("dut word", bus, q1.pop_front());
      end
      if (valid_nc && !stall_nc) begin
        if (q2.size() == 0) check("nc unexpected word", bus_nc, 128'd0);
        else check("nc word", bus_nc, q2.pop_front());
      end
    end
  end

  initial begin
    int base;
    logic [127:0] held;
    tbl[0] = '{xs: {9'd10, 9'd30, 9'd10}, ys: {8'd20, 8'd20, 8'd50}, zs: {16'h0100, 16'h0200, 16'hFFFF}, cull: 1'b0};
    tbl[1] = '{xs: {9'd0, 9'd5, 9'd10}, ys: {8'd0, 8'd5, 8'd10}, zs: {16'h0001, 16'h0002, 16'h0003}, cull: 1'b1};
    tbl[2] = '{xs: {9'd100, 9'd300, 9'd511}, ys: {8'd7, 8'd7, 8'd7}, zs: {16'h8000, 16'h7FFF, 16'h1234}, cull: 1'b1};
    tbl[3] = '{xs: {9'd1, 9'd2, 9'd1}, ys: {8'd1, 8'd1, 8'd2}, zs: {16'hAAAA, 16'h5555, 16'h0F0F}, cull: 1'b0};
    tbl[4] = '{xs: {9'd511, 9'd0, 9'd0}, ys: {8'd255, 8'd0, 8'd255}, zs: {16'hFFFE, 16'h0000, 16'h8001}, cull: 1'b0};
    tbl[5] = '{xs: {9'd7, 9'd7, 9'd7}, ys: {8'd7, 8'd7, 8'd7}, zs: {16'h0007, 16'h0007, 16'h0007}, cull: 1'b1};

    repeat (2) @(negedge clk);
    check("reset valid", 128'(valid), 128'd0);
    check("reset bus", bus, 128'd0);
    check("reset vtx_ready", 128'(vtx_ready), 128'd1);
    check("reset cull_count", 128'(cull_count), 128'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single triangle: exact word and one-cycle latency
    cur_cull = 1'b0;
    send_vtx(9'd10, 8'd20, 16'h0100);
    send_vtx(9'd30, 8'd20, 16'h0200);
    check("valid before third vertex", 128'(valid), 128'd0);
    send_vtx(9'd10, 8'd50, 16'hFFFF);
    @(negedge clk);
    check("single valid after 1 cycle", 128'(valid), 128'd1);
    check("single bus", bus, 128'h0000_0100_0014_1432_0028_3C0A_0200_FFFF);
    @(negedge clk);
    check("single valid one cycle", 128'(valid), 128'd0);
    drain();

    // degenerate cull, then the table
    apply_reset();
    send_tri(tbl[1]);
    send_tri(tbl[0]);
    drain();
    check("cull_count after collinear", 128'(cull_count), 128'd1);
    for (int i = 0; i < 6; i++) send_tri(tbl[i]);
    drain();
    check("cull_count after table", 128'(cull_count), 128'(cull_exp));
    check("nc cull_count", 128'(cull_count_nc), 128'd0);

    // backpressure
    frame_pulse();
    stall = 1'b1;
    base = acc_total;
    fork
      begin
        for (int i = 0; i < 5; i++) send_tri(tbl[(i % 3 == 0) ? 0 : (i % 3 == 1) ? 3 : 4]);
      end
      begin
        for (int t = 0; t < 300 && acc_total < base + 14; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("bp accepted 14", 128'(acc_total - base), 128'd14);
        check("bp vtx_ready low", 128'(vtx_ready), 128'd0);
        check("bp valid held", 128'(valid), 128'd1);
        check("bp head tid", 128'(bus[127:112]), 128'd0);
        held = bus;
        repeat (3) @(negedge clk);
        check("bp bus stable", bus, held);
        @(posedge clk);
        #1;
        stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp no gap", 128'(valid), 128'd1);
        end
        @(negedge clk);
        check("bp empty after 5", 128'(valid), 128'd0);
      end
    join
    drain();

    // tid wrap
    @(negedge clk);
    force u_dut.r_tid = 16'hFFFE;
    force u_nc.r_tid = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release u_dut.r_tid;
    release u_nc.r_tid;
    tid1 = 16'hFFFE;
    tid2 = 16'hFFFE;
    @(posedge clk);
    #1;
    send_tri(tbl[0]);
    send_tri(tbl[3]);
    send_tri(tbl[4]);
    drain();

    // frame_start drops a partial triangle and restarts tid
    cur_cull = 1'b0;
    send_vtx(9'd200, 8'd100, 16'h4444);
    send_vtx(9'd201, 8'd101, 16'h5555);
    frame_pulse();
    send_tri(tbl[3]);
    drain();

    // async reset while stalled with queued words
    stall = 1'b1;
    for (int i = 0; i < 3; i++) send_tri(tbl[0]);
    @(negedge clk);
    check("pre-reset valid", 128'(valid), 128'd1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("async reset valid", 128'(valid), 128'd0);
    check("async reset bus", bus, 128'd0);
    check("async reset vtx_ready", 128'(vtx_ready), 128'd1);
    check("async reset cull_count", 128'(cull_count), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_tri(tbl[3]);
    @(negedge clk);
    check("post-reset tid", 128'(bus[127:112]), 128'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
